// File: rtl/slap_probe_pkg.sv
// Shared types and constants for the latency probe.
package slap_probe_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StWait,
    StDone
  } state_e;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/slap_sync2.sv
// Two-flop synchronizer for the echo input.
module slap_sync2
  import slap_probe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/slap_latency_probe.sv
// Fires a one-cycle probe into a delay path and counts edges until it returns.
// Define SLAP_PROBE_SYNC_EN to route echo_in through a 2-flop synchronizer.
module slap_latency_probe
  import slap_probe_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             echo_in,
  output logic             probe_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] latency,
  output logic             timeout,
  output logic             stuck
);

  logic echo;

`ifdef SLAP_PROBE_SYNC_EN
  localparam int unsigned Lag = SYNC_STAGES;
  slap_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo_in),
    .q     (echo)
  );
`else
  localparam int unsigned Lag = 0;
  assign echo = echo_in;
`endif

  // Two spare bits so the raw count can reach MAX_WAIT plus the synchronizer lag.
  localparam int unsigned      CW        = CNT_W + 2;
  localparam logic [CW-1:0]    WaitLimit = CW'(MAX_WAIT + Lag);
  localparam logic [CW-1:0]    ArmLimit  = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0]    LagC      = CW'(Lag);
  localparam logic [CNT_W-1:0] MaxLat    = CNT_W'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] latency_q, latency_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic             probe_q, done_q, busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latency_d = latency_q;
    timeout_d = timeout_q;
    stuck_d   = stuck_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StArm;
          cnt_d   = '0;
        end
      end
      StArm: begin
        if (!echo) begin
          state_d = StFire;
          cnt_d   = '0;
        end else if (cnt_q >= ArmLimit) begin
          state_d   = StDone;
          latency_d = '0;
          timeout_d = 1'b1;
          stuck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFire, StWait: begin
        // Echo is checked before the limit so a last-cycle echo still counts.
        if (echo) begin
          state_d   = StDone;
          latency_d = (cnt_q > LagC) ? CNT_W'(cnt_q - LagC) : '0;
          timeout_d = 1'b0;
          stuck_d   = 1'b0;
        end else if (cnt_q >= WaitLimit) begin
          state_d   = StDone;
          latency_d = MaxLat;
          timeout_d = 1'b1;
          stuck_d   = 1'b0;
        end else begin
          state_d = StWait;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      latency_q <= '0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
      probe_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      latency_q <= latency_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
      probe_q   <= (state_d == StFire);
      done_q    <= (state_d == StDone);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign probe_out = probe_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign latency   = latency_q;
  assign timeout   = timeout_q;
  assign stuck     = stuck_q;

endmodule
